mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares the single higher-level memory port between `NUM_REQ` cache-side requesters. Each requester can issue a block read or a block evict (write-back). The arbiter latches one transaction at a time, drives it on the memory port, and returns the completion to the winning requester only. It sits between the main-memory cache instances (or the I/D cache pair) and the next memory level.

## Interface

**Parameters**
- `NUM_REQ`, default 2: number of requester ports, ≥2.
- `BLOCK_BITS`, default 512: block width in bits.
- `GW` (localparam) = `$clog2(NUM_REQ)`.

**Ports** (clock and reset first)
- `clk_i`, in, 1: single clock, rising edge.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, NUM_REQ: per-requester read request. Level signal, held until its `req_valid_o` bit pulses.
- `req_addr_i`, in, NUM_REQ*32: read addresses; slice k is `[32*k +: 32]`.
- `evict_req_i`, in, NUM_REQ: per-requester evict request. Level signal, held until its `evict_ack_o` bit pulses.
- `evict_addr_i`, in, NUM_REQ*32: evict addresses.
- `evict_data_i`, in, NUM_REQ*BLOCK_BITS: evict data blocks.
- `req_valid_o`, out, NUM_REQ: one-cycle read-complete pulse, asserted only on the granted bit.
- `req_data_o`, out, BLOCK_BITS: read block, shared by all requesters. Valid while any `req_valid_o` bit is high.
- `req_addr_o`, out, 32: block address of the returned read, with bits `[5:0]` = 0.
- `evict_ack_o`, out, NUM_REQ: one-cycle evict-complete pulse on the granted bit.
- `busy_o`, out, 1: high in every state except IDLE.
- `grant_o`, out, GW: index of the current or last granted requester.
- `mem_request_o`, out, 1: read request to the memory level.
- `mem_addr_o`, out, 32: read address.
- `mem_data_i`, in, BLOCK_BITS: read data from the memory level.
- `mem_request_valid_i`, in, 1: read data valid.
- `mem_evict_o`, out, 1: evict request to the memory level.
- `mem_evict_addr_o`, out, 32: evict address.
- `mem_evict_data_o`, out, BLOCK_BITS: evict data.
- `mem_evict_i`, in, 1: evict accepted by the memory level.

## Operation

**States:** IDLE, RD, WR, RESP.

**IDLE**
- Arbitration candidate k = `req_i[k] | evict_req_i[k]`.
- Scan starts at round-robin pointer `ptr` and increments modulo NUM_REQ. The first candidate found wins and becomes g.
- Within a requester, evict has priority over read. This preserves write-then-read ordering for the same block.
- On a win, latch into internal registers:
  - g;
  - the operation type;
  - the address with bits `[5:0]` forced to 0;
  - for an evict, the data block.
- After latching, go to RD or WR. With no candidate, stay in IDLE.

**RD**
- `mem_request_o`=1, with `mem_addr_o` driven from the latched address.
- On `mem_request_valid_i`, register `mem_data_i` into the response register and go to RESP.

**WR**
- `mem_evict_o`=1, with `mem_evict_addr_o` and `mem_evict_data_o` driven from the latched values.
- On `mem_evict_i`, go to RESP.

**RESP**
- Pulse `req_valid_o[g]` for a read, or `evict_ack_o[g]` for an evict.
- `req_addr_o` = latched address.
- Set `ptr` = (g+1) mod NUM_REQ, then go to IDLE.

**General rules**
- Requester inputs are sampled only in IDLE. Later changes, including a dropped request, do not abort the transaction, and the completion pulse is still issued.
- `mem_request_valid_i` outside RD and `mem_evict_i` outside WR are ignored.
- `req_data_o` and `req_addr_o` hold their last value until the next read completion.
- `mem_addr_o`, `mem_evict_addr_o` and `mem_evict_data_o` are 0 whenever their strobe is low.
- Non-power-of-2 NUM_REQ: pointer wrap is a compare with NUM_REQ-1, not a bit truncation.

## Timing

- **Reset:** asynchronous. Values while reset is asserted:
  - state = IDLE, `ptr`=0, `grant_o`=0, `busy_o`=0;
  - all strobes and pulses = 0;
  - `req_data_o`, `req_addr_o` and all mem address/data outputs = 0.
- **Reset mid-transaction:** the transaction is dropped with no completion pulse, and the memory strobe falls immediately.
- **Read latency:**
  - Request visible in IDLE at cycle 0.
  - `mem_request_o` high from cycle 1.
  - `mem_request_valid_i` arrives at cycle k ≥ 1.
  - `req_valid_o` pulses at cycle k+1.
  - Back in IDLE at cycle k+2, which is the next arbitration.
- **Evict latency:** identical, using `mem_evict_o` / `mem_evict_i` / `evict_ack_o`.
- **Minimum occupancy:** 3 cycles per transaction.
- **Requester handshake:**
  - A requester drops its level on the edge where it samples its pulse, so it is not re-granted in the following IDLE.
  - A requester that keeps its level asserted is treated as a new request.
- **Simultaneous read and evict from the same requester:** the evict is served first. The read stays pending and competes again after the pointer moves past that requester.
- **Fairness:** every asserted requester is served within NUM_REQ transactions.

## Test plan

- **Reset values:** assert `rst_n_i`=0 mid-RD → all outputs 0 asynchronously, no pulse; after release with no requests, `busy_o`=0 and state stays IDLE.
- **Single read:** `req_i`=01, `req_addr_i[0]`=0x1234_5678; memory returns `mem_request_valid_i` 4 cycles after `mem_request_o` rises → `mem_addr_o`=0x1234_5640, `req_valid_o`=01 for exactly 1 cycle, `req_data_o` equals the returned block, `req_addr_o`=0x1234_5640.
- **Round-robin:** both requesters hold `req_i`=11 continuously → grants alternate 0,1,0,1 with `ptr` advancing; no requester is granted twice in a row.
- **Evict priority:** requester 0 asserts `evict_req_i` and `req_i` together with addr 0x0000_0080 and data pattern A5… → WR is served first, `mem_evict_data_o`=A5…, `evict_ack_o[0]` pulses; the read is granted afterwards.
- **Stale handshakes:** pulse `mem_request_valid_i` in IDLE and `mem_evict_i` in RD → no state change and no pulses.
- **Request dropped:** requester 1 drops `req_i` during RD → the transaction still completes and `req_valid_o`=10 pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among cache requesters
module mem_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int BLOCK_BITS = 512
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*32-1:0]         req_addr_i,
    input  logic [NUM_REQ-1:0]            evict_req_i,
    input  logic [NUM_REQ*32-1:0]         evict_addr_i,
    input  logic [NUM_REQ*BLOCK_BITS-1:0] evict_data_i,
    output logic [NUM_REQ-1:0]            req_valid_o,
    output logic [BLOCK_BITS-1:0]         req_data_o,
    output logic [31:0]                   req_addr_o,
    output logic [NUM_REQ-1:0]            evict_ack_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_o,
    output logic                          mem_request_o,
    output logic [31:0]                   mem_addr_o,
    input  logic [BLOCK_BITS-1:0]         mem_data_i,
    input  logic                          mem_request_valid_i,
    output logic                          mem_evict_o,
    output logic [31:0]                   mem_evict_addr_o,
    output logic [BLOCK_BITS-1:0]         mem_evict_data_o,
    input  logic                          mem_evict_i
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  r_state;
    logic [GW-1:0]           r_ptr;
    logic [GW-1:0]           r_grant;
    logic                    r_is_evict;
    logic [31:0]             r_addr;
    logic [NUM_REQ-1:0]      r_req_valid;
    logic [NUM_REQ-1:0]      r_evict_ack;
    logic [BLOCK_BITS-1:0]   r_req_data;
    logic [31:0]             r_req_addr;
    logic                    r_mem_request;
    logic [31:0]             r_mem_addr;
    logic                    r_mem_evict;
    logic [31:0]             r_mem_evict_addr;
    logic [BLOCK_BITS-1:0]   r_mem_evict_data;

    logic [NUM_REQ-1:0]      w_cand;
    logic                    w_found;
    logic [GW-1:0]           w_win;
    logic [GW:0]             w_idx;
    logic                    w_win_evict;
    logic [31:0]             w_win_addr;
    logic [GW-1:0]           w_next_ptr;

    assign w_cand = req_i | evict_req_i;

    // Scan from the pointer; the index wraps by compare so any NUM_REQ works.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (GW+1)'(i);
            if (w_idx >= (GW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (GW+1)'(NUM_REQ);
            end
            if (!w_found && w_cand[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[GW-1:0];
            end
        end
    end

    // Evict wins over read inside one requester to keep write-then-read order.
    assign w_win_evict = evict_req_i[w_win];
    assign w_win_addr  = w_win_evict ? {evict_addr_i[32*w_win+6 +: 26], 6'b0}
                                     : {req_addr_i[32*w_win+6 +: 26], 6'b0};
    assign w_next_ptr  = (r_grant == GW'(NUM_REQ-1)) ? '0 : r_grant + GW'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state          <= IDLE;
            r_ptr            <= '0;
            r_grant          <= '0;
            r_is_evict       <= 1'b0;
            r_addr           <= '0;
            r_req_valid      <= '0;
            r_evict_ack      <= '0;
            r_req_data       <= '0;
            r_req_addr       <= '0;
            r_mem_request    <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_evict      <= 1'b0;
            r_mem_evict_addr <= '0;
            r_mem_evict_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_win;
                        r_is_evict <= w_win_evict;
                        r_addr     <= w_win_addr;
                        if (w_win_evict) begin
                            r_mem_evict      <= 1'b1;
                            r_mem_evict_addr <= w_win_addr;
                            r_mem_evict_data <= evict_data_i[BLOCK_BITS*w_win +: BLOCK_BITS];
                            r_state          <= WR;
                        end else begin
                            r_mem_request <= 1'b1;
                            r_mem_addr    <= w_win_addr;
                            r_state       <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_request_valid_i) begin
                        r_req_data           <= mem_data_i;
                        r_req_addr           <= r_addr;
                        r_req_valid[r_grant] <= 1'b1;
                        r_mem_request        <= 1'b0;
                        r_mem_addr           <= '0;
                        r_state              <= RESP;
                    end
                end
                WR: begin
                    if (mem_evict_i) begin
                        r_evict_ack[r_grant] <= 1'b1;
                        r_mem_evict          <= 1'b0;
                        r_mem_evict_addr     <= '0;
                        r_mem_evict_data     <= '0;
                        r_state              <= RESP;
                    end
                end
                RESP: begin
                    r_req_valid <= '0;
                    r_evict_ack <= '0;
                    r_ptr       <= w_next_ptr;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_valid_o      = r_req_valid;
    assign req_data_o       = r_req_data;
    assign req_addr_o       = r_req_addr;
    assign evict_ack_o      = r_evict_ack;
    assign busy_o           = (r_state != IDLE);
    assign grant_o          = r_grant;
    assign mem_request_o    = r_mem_request;
    assign mem_addr_o       = r_mem_addr;
    assign mem_evict_o      = r_mem_evict;
    assign mem_evict_addr_o = r_mem_evict_addr;
    assign mem_evict_data_o = r_mem_evict_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int BB = 512;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic [NR-1:0]   req_i = '0;
    logic [NR*32-1:0] req_addr_i;
    logic [NR-1:0]   evict_req_i = '0;
    logic [NR*32-1:0] evict_addr_i;
    logic [NR*BB-1:0] evict_data_i;
    logic [NR-1:0]   req_valid_o;
    logic [BB-1:0]   req_data_o;
    logic [31:0]     req_addr_o;
    logic [NR-1:0]   evict_ack_o;
    logic            busy_o;
    logic [0:0]      grant_o;
    logic            mem_request_o;
    logic [31:0]     mem_addr_o;
    logic [BB-1:0]   mem_data_i = '0;
    logic            mem_request_valid_i = 1'b0;
    logic            mem_evict_o;
    logic [31:0]     mem_evict_addr_o;
    logic [BB-1:0]   mem_evict_data_o;
    logic            mem_evict_i = 1'b0;

    mem_port_arbiter #(.NUM_REQ(NR), .BLOCK_BITS(BB)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_i(req_i), .req_addr_i(req_addr_i),
        .evict_req_i(evict_req_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
        .req_valid_o(req_valid_o), .req_data_o(req_data_o), .req_addr_o(req_addr_o),
        .evict_ack_o(evict_ack_o), .busy_o(busy_o), .grant_o(grant_o),
        .mem_request_o(mem_request_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .mem_request_valid_i(mem_request_valid_i),
        .mem_evict_o(mem_evict_o), .mem_evict_addr_o(mem_evict_addr_o),
        .mem_evict_data_o(mem_evict_data_o), .mem_evict_i(mem_evict_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  ev;
        int          lat;
        logic        g;
        logic        is_ev;
        logic [31:0] addr;
    } vec_t;

    vec_t          vecs[11];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [BB-1:0] edata0, edata1, last_rdata;
    logic [31:0]   last_raddr;

    task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_valid"}, BB'(req_valid_o), '0);
        chk({tag, " evict_ack"}, BB'(evict_ack_o), '0);
        chk({tag, " busy"}, BB'(busy_o), '0);
        chk({tag, " grant"}, BB'(grant_o), '0);
        chk({tag, " mem_request"}, BB'(mem_request_o), '0);
        chk({tag, " mem_addr"}, BB'(mem_addr_o), '0);
        chk({tag, " mem_evict"}, BB'(mem_evict_o), '0);
        chk({tag, " mem_evict_addr"}, BB'(mem_evict_addr_o), '0);
        chk({tag, " mem_evict_data"}, mem_evict_data_o, '0);
        chk({tag, " req_data"}, req_data_o, '0);
        chk({tag, " req_addr"}, BB'(req_addr_o), '0);
    endtask

    // Applies one row in IDLE and walks it through strobe, completion and return to IDLE.
    task automatic run_row(input vec_t v, input int idx);
        logic [BB-1:0] rdata;
        logic [1:0]    onehot;
        rdata  = {16{32'h1000_0000 + 32'(idx)}};
        onehot = 2'b01 << v.g;
        req_i = v.req;
        evict_req_i = v.ev;
        @(negedge clk_i);
        chk($sformatf("r%0d grant", idx), BB'(grant_o), BB'(v.g));
        chk($sformatf("r%0d busy", idx), BB'(busy_o), BB'(1));
        chk($sformatf("r%0d mem_request", idx), BB'(mem_request_o), BB'(!v.is_ev));
        chk($sformatf("r%0d mem_evict", idx), BB'(mem_evict_o), BB'(v.is_ev));
        chk($sformatf("r%0d mem_addr", idx), BB'(mem_addr_o), v.is_ev ? '0 : BB'(v.addr));
        chk($sformatf("r%0d mem_evict_addr", idx), BB'(mem_evict_addr_o), v.is_ev ? BB'(v.addr) : '0);
        chk($sformatf("r%0d mem_evict_data", idx), mem_evict_data_o,
            v.is_ev ? (v.g ? edata1 : edata0) : '0);
        repeat (v.lat) @(negedge clk_i);
        chk($sformatf("r%0d strobe held", idx), BB'(v.is_ev ? mem_evict_o : mem_request_o), BB'(1));
        if (v.is_ev) mem_evict_i = 1'b1;
        else begin
            mem_request_valid_i = 1'b1;
            mem_data_i = rdata;
        end
        @(negedge clk_i);
        mem_evict_i = 1'b0;
        mem_request_valid_i = 1'b0;
        mem_data_i = '0;
        if (!v.is_ev) begin
            last_rdata = rdata;
            last_raddr = v.addr;
        end
        chk($sformatf("r%0d req_valid", idx), BB'(req_valid_o), v.is_ev ? '0 : BB'(onehot));
        chk($sformatf("r%0d evict_ack", idx), BB'(evict_ack_o), v.is_ev ? BB'(onehot) : '0);
        chk($sformatf("r%0d req_data", idx), req_data_o, last_rdata);
        chk($sformatf("r%0d req_addr", idx), BB'(req_addr_o), BB'(last_raddr));
        chk($sformatf("r%0d strobes low", idx), BB'({mem_request_o, mem_evict_o}), '0);
        chk($sformatf("r%0d mem addrs zero", idx), BB'({mem_addr_o, mem_evict_addr_o}), '0);
        @(negedge clk_i);
        chk($sformatf("r%0d pulse end", idx), BB'({req_valid_o, evict_ack_o}), '0);
        chk($sformatf("r%0d idle", idx), BB'(busy_o), '0);
    endtask

    initial begin
        edata0 = {64{8'hA5}};
        edata1 = {16{32'hDEAD_BEEF}};
        last_rdata = '0;
        last_raddr = '0;
        req_addr_i   = {32'hABCD_EF3F, 32'h1234_5678};
        evict_addr_i = {32'hFFFF_FFFF, 32'h0000_00A5};
        evict_data_i = {edata1, edata0};

        vecs[0]  = '{2'b01, 2'b00, 4, 1'b0, 1'b0, 32'h1234_5640};
        vecs[1]  = '{2'b11, 2'b00, 0, 1'b1, 1'b0, 32'hABCD_EF00};
        vecs[2]  = '{2'b11, 2'b00, 1, 1'b0, 1'b0, 32'h1234_5640};
        vecs[3]  = '{2'b11, 2'b00, 2, 1'b1, 1'b0, 32'hABCD_EF00};
        vecs[4]  = '{2'b01, 2'b01, 1, 1'b0, 1'b1, 32'h0000_0080};
        vecs[5]  = '{2'b01, 2'b00, 0, 1'b0, 1'b0, 32'h1234_5640};
        vecs[6]  = '{2'b10, 2'b11, 2, 1'b1, 1'b1, 32'hFFFF_FFC0};
        vecs[7]  = '{2'b10, 2'b01, 0, 1'b0, 1'b1, 32'h0000_0080};
        vecs[8]  = '{2'b10, 2'b00, 2, 1'b1, 1'b0, 32'hABCD_EF00};
        vecs[9]  = '{2'b11, 2'b10, 1, 1'b0, 1'b0, 32'h1234_5640};
        vecs[10] = '{2'b00, 2'b10, 3, 1'b1, 1'b1, 32'hFFFF_FFC0};

        repeat (2) @(negedge clk_i);
        chk_all_zero("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("post-reset idle", BB'(busy_o), '0);

        for (int i = 0; i < 11; i++) run_row(vecs[i], i);
        req_i = '0;
        evict_req_i = '0;

        // Stale memory handshakes: valid in IDLE, evict ack in RD.
        mem_request_valid_i = 1'b1;
        mem_data_i = {16{32'h5555_AAAA}};
        @(negedge clk_i);
        mem_request_valid_i = 1'b0;
        mem_data_i = '0;
        chk("stale valid busy", BB'(busy_o), '0);
        chk("stale valid pulse", BB'(req_valid_o), '0);
        chk("stale valid data", req_data_o, last_rdata);
        req_i = 2'b10;
        @(negedge clk_i);
        chk("drop grant", BB'(grant_o), BB'(1));
        chk("drop mem_addr", BB'(mem_addr_o), BB'(32'hABCD_EF00));
        req_i = 2'b00;
        mem_evict_i = 1'b1;
        @(negedge clk_i);
        mem_evict_i = 1'b0;
        chk("stale evict strobe", BB'(mem_request_o), BB'(1));
        chk("stale evict ack", BB'(evict_ack_o), '0);
        mem_request_valid_i = 1'b1;
        mem_data_i = {16{32'h0BAD_F00D}};
        @(negedge clk_i);
        mem_request_valid_i = 1'b0;
        mem_data_i = '0;
        chk("drop req_valid", BB'(req_valid_o), BB'(2'b10));
        chk("drop req_data", req_data_o, {16{32'h0BAD_F00D}});
        last_rdata = {16{32'h0BAD_F00D}};
        last_raddr = 32'hABCD_EF00;
        repeat (2) @(negedge clk_i);
        chk("drop single pulse", BB'(req_valid_o), '0);
        chk("drop no regrant", BB'(busy_o), '0);

        // Moves the pointer to 1, then reset mid-RD must clear it back to 0.
        run_row('{2'b01, 2'b00, 1, 1'b0, 1'b0, 32'h1234_5640}, 20);
        req_i = 2'b10;
        @(negedge clk_i);
        chk("pre-reset rd", BB'(mem_request_o), BB'(1));
        req_i = 2'b00;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("async reset");
        mem_request_valid_i = 1'b1;
        @(negedge clk_i);
        mem_request_valid_i = 1'b0;
        chk("reset no pulse", BB'(req_valid_o), '0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("release idle", BB'(busy_o), '0);
        chk("release no strobe", BB'(mem_request_o), '0);
        last_rdata = '0;
        last_raddr = '0;
        run_row('{2'b11, 2'b00, 0, 1'b0, 1'b0, 32'h1234_5640}, 21);
        req_i = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
